cs_encoder_ctrl: RTL

CS_ENCODER_CTRL -- requirements
Module: cs_encoder_ctrl

---
 rtl/cs_encoder_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cs_encoder_ctrl.sv
// Frame controller around a coefficient-matrix encoder: loads M symbols,
// holds them and the coefficient matrix steady for the encoder for one
// cycle, captures the result, then streams M encoded/payload beats out.
// Ports: clk, rst_n (sync, active-low); s_valid/s_ready/s_data input beats;
// cfg_we/cfg_addr/cfg_data coefficient writes, cfg_err dropped-write pulse;
// dec_symbols_flat/enc_coeffs_flat to encoder; enc_symbols_flat/sym_out_flat
// from encoder; m_valid/m_ready/m_data/m_payload/m_last output beats;
// frames_done completed-frame counter.
module cs_encoder_ctrl #(
    parameter int M      = 3,
    parameter int WIDTH  = 11,
    parameter int DATA_W = WIDTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     cfg_we,
    input  logic [$clog2(M*M)-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]         cfg_data,
    output logic                     cfg_err,
    output logic [M*WIDTH-1:0]       dec_symbols_flat,
    output logic [M*M*WIDTH-1:0]     enc_coeffs_flat,
    input  logic [M*WIDTH-1:0]       enc_symbols_flat,
    input  logic [M*DATA_W-1:0]      sym_out_flat,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic [DATA_W-1:0]        m_payload,
    output logic                     m_last,
    output logic [15:0]              frames_done
);

    localparam int NC = M * M;
    localparam int AW = $clog2(NC);
    localparam int IW = ($clog2(M) > 1) ? $clog2(M) : 1;
    localparam logic [AW:0]   NC_W     = (AW + 1)'(NC);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        SEND
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  sym_q  [M];
    logic [WIDTH-1:0]  sym_d  [M];
    logic [WIDTH-1:0]  coef_q [NC];
    logic [WIDTH-1:0]  coef_d [NC];
    logic [WIDTH-1:0]  enc_q  [M];
    logic [WIDTH-1:0]  enc_d  [M];
    logic [DATA_W-1:0] pay_q  [M];
    logic [DATA_W-1:0] pay_d  [M];
    logic              cfg_err_q, cfg_err_d;
    logic [15:0]       frames_q, frames_d;
    logic              cfg_ok;

    // Coefficients may only change between frames, so the encoder never
    // sees a matrix that is half old and half new.
    assign cfg_ok = cfg_we && (state_q == LOAD) && (idx_q == '0)
                    && ({1'b0, cfg_addr} < NC_W);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sym_d     = sym_q;
        coef_d    = coef_q;
        enc_d     = enc_q;
        pay_d     = pay_q;
        frames_d  = frames_q;
        cfg_err_d = cfg_we && !cfg_ok;

        if (cfg_ok) begin
            coef_d[cfg_addr] = cfg_data;
        end

        unique case (state_q)
            LOAD: begin
                if (s_valid) begin
                    sym_d[idx_q] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = CALC;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CALC: begin
                for (int r = 0; r < M; r++) begin
                    enc_d[r] = enc_symbols_flat[r*WIDTH +: WIDTH];
                    pay_d[r] = sym_out_flat[r*DATA_W +: DATA_W];
                end
                state_d = SEND;
            end
            SEND: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d    = '0;
                        state_d  = LOAD;
                        frames_d = frames_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            sym_q     <= '{default: '0};
            coef_q    <= '{default: '0};
            enc_q     <= '{default: '0};
            pay_q     <= '{default: '0};
            cfg_err_q <= 1'b0;
            frames_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sym_q     <= sym_d;
            coef_q    <= coef_d;
            enc_q     <= enc_d;
            pay_q     <= pay_d;
            cfg_err_q <= cfg_err_d;
            frames_q  <= frames_d;
        end
    end

    for (genvar r = 0; r < M; r++) begin : g_sym
        assign dec_symbols_flat[r*WIDTH +: WIDTH] = sym_q[r];
    end

    for (genvar i = 0; i < NC; i++) begin : g_coef
        assign enc_coeffs_flat[i*WIDTH +: WIDTH] = coef_q[i];
    end

    // All handshake outputs come from state flops only, so neither
    // m_ready nor s_valid reaches the opposite side combinationally.
    assign s_ready     = (state_q == LOAD);
    assign m_valid     = (state_q == SEND);
    assign m_last      = m_valid && (idx_q == LAST_IDX);
    assign m_data      = enc_q[idx_q];
    assign m_payload   = pay_q[idx_q];
    assign cfg_err     = cfg_err_q;
    assign frames_done = frames_q;

endmodule
